// File: rtl/sme_host_driver.sv
// Host-side driver for the string-matching engine: buffers one string and one pattern,
// streams them onto the engine byte bus on start, and returns the engine result with a timeout.
module sme_host_driver #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       str_wr,
    input  logic       pat_wr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       keep_str,
    output logic       busy,
    output logic       err,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout
);

    localparam int unsigned SIW = $clog2(STR_MAX);
    localparam int unsigned SCW = $clog2(STR_MAX + 1);
    localparam int unsigned PIW = $clog2(PAT_MAX);
    localparam int unsigned PCW = $clog2(PAT_MAX + 1);
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSendStr = 3'd1;
    localparam logic [2:0] StSendPat = 3'd2;
    localparam logic [2:0] StWait    = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];

    logic [2:0]     state_q, state_d;
    logic [SCW-1:0] str_cnt_q, str_cnt_d;
    logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
    logic           str_sent_q, str_sent_d;
    logic [SCW-1:0] idx_q, idx_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic           res_valid_q, res_valid_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           res_timeout_q, res_timeout_d;

    logic           str_we, pat_we;
    logic [SIW-1:0] str_waddr;
    logic           skip_str;

    assign skip_str = keep_str && str_sent_q;

    always_comb begin
        state_d       = state_q;
        str_cnt_d     = str_cnt_q;
        pat_cnt_d     = pat_cnt_q;
        str_sent_d    = str_sent_q;
        idx_d         = idx_q;
        wcnt_d        = wcnt_q;
        busy_d        = busy_q;
        err_d         = 1'b0;
        chardata_d    = chardata_q;
        isstring_d    = isstring_q;
        ispattern_d   = ispattern_q;
        res_valid_d   = 1'b0;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;
        str_we        = 1'b0;
        pat_we        = 1'b0;
        str_waddr     = str_cnt_q[SIW-1:0];

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (pat_cnt_q == '0 || (str_cnt_q == '0 && !skip_str)) begin
                        err_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        idx_d  = SCW'(1);
                        if (skip_str) begin
                            state_d     = StSendPat;
                            chardata_d  = pat_buf[0];
                            ispattern_d = 1'b1;
                        end else begin
                            state_d    = StSendStr;
                            chardata_d = str_buf[0];
                            isstring_d = 1'b1;
                        end
                    end
                end else if (str_wr && pat_wr) begin
                    err_d = 1'b1;
                end else if (str_wr) begin
                    // A string already sent is replaced by a fresh one from slot 0.
                    if (str_sent_q) begin
                        str_we     = 1'b1;
                        str_waddr  = '0;
                        str_cnt_d  = SCW'(1);
                        str_sent_d = 1'b0;
                    end else if (str_cnt_q == SCW'(STR_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        str_we    = 1'b1;
                        str_cnt_d = str_cnt_q + SCW'(1);
                    end
                end else if (pat_wr) begin
                    if (pat_cnt_q == PCW'(PAT_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        pat_we    = 1'b1;
                        pat_cnt_d = pat_cnt_q + PCW'(1);
                    end
                end
            end

            StSendStr: begin
                if (idx_q == str_cnt_q) begin
                    state_d     = StSendPat;
                    isstring_d  = 1'b0;
                    ispattern_d = 1'b1;
                    chardata_d  = pat_buf[0];
                    idx_d       = SCW'(1);
                end else begin
                    chardata_d = str_buf[idx_q[SIW-1:0]];
                    idx_d      = idx_q + SCW'(1);
                end
            end

            StSendPat: begin
                if (idx_q == SCW'(pat_cnt_q)) begin
                    state_d     = StWait;
                    ispattern_d = 1'b0;
                    chardata_d  = 8'h00;
                    wcnt_d      = '0;
                end else begin
                    chardata_d = pat_buf[idx_q[PIW-1:0]];
                    idx_d      = idx_q + SCW'(1);
                end
            end

            StWait: begin
                if (sme_valid) begin
                    state_d       = StDone;
                    res_valid_d   = 1'b1;
                    res_match_d   = sme_match;
                    res_index_d   = sme_match_index;
                    res_timeout_d = 1'b0;
                end else if (wcnt_q == WCW'(TIMEOUT)) begin
                    state_d       = StDone;
                    res_valid_d   = 1'b1;
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end

            StDone: begin
                state_d    = StIdle;
                busy_d     = 1'b0;
                pat_cnt_d  = '0;
                str_sent_d = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            str_cnt_q     <= '0;
            pat_cnt_q     <= '0;
            str_sent_q    <= 1'b0;
            idx_q         <= '0;
            wcnt_q        <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            chardata_q    <= 8'h00;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= 5'd0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            str_cnt_q     <= str_cnt_d;
            pat_cnt_q     <= pat_cnt_d;
            str_sent_q    <= str_sent_d;
            idx_q         <= idx_d;
            wcnt_q        <= wcnt_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            chardata_q    <= chardata_d;
            isstring_q    <= isstring_d;
            ispattern_q   <= ispattern_d;
            res_valid_q   <= res_valid_d;
            res_match_q   <= res_match_d;
            res_index_q   <= res_index_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (str_we) str_buf[str_waddr] <= wr_data;
        if (pat_we) pat_buf[pat_cnt_q[PIW-1:0]] <= wr_data;
    end

    assign busy        = busy_q;
    assign err         = err_q;
    assign chardata    = chardata_q;
    assign isstring    = isstring_q;
    assign ispattern   = ispattern_q;
    assign res_valid   = res_valid_q;
    assign res_match   = res_match_q;
    assign res_index   = res_index_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Directed bench for sme_host_driver: byte streaming, engine results, timeout, errors and reset.
module tb_sme_host_driver;

    localparam int TIMEOUT = 63;

    logic       clk;
    logic       reset;
    logic       str_wr, pat_wr, start, keep_str;
    logic [7:0] wr_data;
    logic       busy, err, isstring, ispattern;
    logic [7:0] chardata;
    logic       sme_valid, sme_match;
    logic [4:0] sme_match_index;
    logic       res_valid, res_match, res_timeout;
    logic [4:0] res_index;

    int n_checks = 0;
    int n_fail   = 0;

    sme_host_driver #(
        .STR_MAX(32),
        .PAT_MAX(8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .str_wr         (str_wr),
        .pat_wr         (pat_wr),
        .wr_data        (wr_data),
        .start          (start),
        .keep_str       (keep_str),
        .busy           (busy),
        .err            (err),
        .chardata       (chardata),
        .isstring       (isstring),
        .ispattern      (ispattern),
        .sme_valid      (sme_valid),
        .sme_match      (sme_match),
        .sme_match_index(sme_match_index),
        .res_valid      (res_valid),
        .res_match      (res_match),
        .res_index      (res_index),
        .res_timeout    (res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_str(input logic [7:0] c);
        str_wr = 1'b1; wr_data = c; tick(); str_wr = 1'b0;
    endtask

    task automatic put_pat(input logic [7:0] c);
        pat_wr = 1'b1; wr_data = c; tick(); pat_wr = 1'b0;
    endtask

    task automatic fire(input logic ks);
        start = 1'b1; keep_str = ks; tick(); start = 1'b0; keep_str = 1'b0;
    endtask

    // Engine model: one-cycle result strobe while the driver waits.
    task automatic engine(input logic m, input logic [4:0] ix);
        sme_valid = 1'b1; sme_match = m; sme_match_index = ix; tick();
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        str_wr = 0; pat_wr = 0; start = 0; keep_str = 0; wr_data = 8'h00;
        sme_valid = 0; sme_match = 0; sme_match_index = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_chardata", chardata, 0);
        chk("rst_isstring", isstring, 0);
        chk("rst_ispattern", ispattern, 0);
        chk("rst_res", {res_valid, res_match, res_index, res_timeout}, 0);
        reset = 1'b0;
        tick();

        // Job 1: "abcde" / "cd"
        put_str(8'h61); put_str(8'h62); put_str(8'h63); put_str(8'h64); put_str(8'h65);
        put_pat(8'h63); put_pat(8'h64);
        chk("load_no_err", err, 0);
        fire(1'b0);
        chk("j1_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            chk("j1_isstring", isstring, 1);
            chk("j1_ispattern_lo", ispattern, 0);
            chk("j1_str_byte", chardata, 32'h61 + i);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("j1_ispattern", ispattern, 1);
            chk("j1_isstring_lo", isstring, 0);
            chk("j1_pat_byte", chardata, 32'h63 + i);
            tick();
        end
        chk("j1_wait_quals", {isstring, ispattern}, 0);
        chk("j1_wait_chardata", chardata, 0);
        chk("j1_wait_res_valid", res_valid, 0);
        engine(1'b1, 5'd2);
        chk("j1_res_valid", res_valid, 1);
        chk("j1_res_match", res_match, 1);
        chk("j1_res_index", res_index, 2);
        chk("j1_res_timeout", res_timeout, 0);
        chk("j1_done_busy", busy, 1);
        tick();
        chk("j1_res_valid_once", res_valid, 0);
        chk("j1_idle_busy", busy, 0);
        chk("j1_res_hold", res_match, 1);

        // Job 2: keep string, pattern "^a"
        put_pat(8'h5E); put_pat(8'h61);
        fire(1'b1);
        chk("j2_ispattern0", ispattern, 1);
        chk("j2_isstring0", isstring, 0);
        chk("j2_byte0", chardata, 32'h5E);
        tick();
        chk("j2_ispattern1", ispattern, 1);
        chk("j2_isstring1", isstring, 0);
        chk("j2_byte1", chardata, 32'h61);
        tick();
        chk("j2_wait_quals", {isstring, ispattern}, 0);
        engine(1'b1, 5'd0);
        chk("j2_res_valid", res_valid, 1);
        chk("j2_res_index", res_index, 0);
        chk("j2_res_match", res_match, 1);
        tick();

        // Job 3: engine stays silent; TIMEOUT+1 WAIT cycles separate last byte and res_valid
        put_pat(8'h78);
        fire(1'b1);
        chk("j3_last_byte", chardata, 32'h78);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 200);
        chk("j3_timeout_latency", n, TIMEOUT + 2);
        chk("j3_res_timeout", res_timeout, 1);
        chk("j3_res_match", res_match, 0);
        chk("j3_res_index", res_index, 0);
        tick();

        // Error cases
        fire(1'b1);
        chk("err_no_pattern", err, 1);
        chk("err_no_pattern_busy", busy, 0);
        tick();
        chk("err_pulse_width", err, 0);
        chk("err_busy_idle", busy, 0);
        str_wr = 1'b1; pat_wr = 1'b1; wr_data = 8'hEE;
        tick();
        str_wr = 1'b0; pat_wr = 1'b0;
        chk("err_both_wr", err, 1);
        for (int i = 0; i < 8; i++) put_pat(8'h40 + 8'(i));
        chk("pat_full_ok", err, 0);
        put_pat(8'hFF);
        chk("err_pat_overflow", err, 1);
        for (int i = 0; i < 32; i++) put_str(8'h20 + 8'(i));
        chk("str_full_ok", err, 0);
        put_str(8'hFF);
        chk("err_str_overflow", err, 1);

        // Full-length job: 32 string bytes then 8 pattern bytes, back to back
        fire(1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("full_isstring", isstring, (i < 32) ? 1 : 0);
            chk("full_ispattern", ispattern, (i < 32) ? 0 : 1);
            chk("full_byte", chardata, (i < 32) ? 32'h20 + i : 32'h40 + (i - 32));
            tick();
        end
        chk("full_wait_quals", {isstring, ispattern}, 0);
        engine(1'b0, 5'd17);
        chk("full_res_valid", res_valid, 1);
        chk("full_res_match", res_match, 0);
        chk("full_res_index", res_index, 17);
        chk("full_res_timeout", res_timeout, 0);
        tick();

        // Reset in the middle of SEND_STR
        put_pat(8'h55);
        fire(1'b0);
        chk("rs_first_byte", chardata, 32'h20);
        chk("rs_isstring", isstring, 1);
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_quals", {isstring, ispattern}, 0);
        chk("rs_chardata", chardata, 0);
        chk("rs_res", {res_valid, res_match, res_index, res_timeout}, 0);
        chk("rs_err", err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        repeat (80) begin
            tick();
            if (res_valid || isstring || ispattern || busy) seen++;
        end
        chk("rs_no_activity", seen, 0);
        fire(1'b0);
        chk("rs_pat_cleared_err", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
